// File: rtl/puzzle1_line_parser.sv
// ASCII rotation-line parser: turns "L68\n"-style lines into {letter, number} words
// for the day-1 dial solver, with syntax checking and valid/ready flow control.
module puzzle1_line_parser #(
    parameter int LETTER_W   = 7,
    parameter int NUM_W      = 10,
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                char_in,
    input  logic                      char_valid,
    output logic                      char_ready,
    input  logic                      eof_in,
    output logic [LETTER_W+NUM_W-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      err_pulse,
    output logic [CNT_W-1:0]          err_count,
    output logic [CNT_W-1:0]          line_count,
    output logic                      done
);

    localparam int ACC_W  = NUM_W + 4;
    localparam int DCNT_W = $clog2(MAX_DIGITS + 2);
    localparam logic [ACC_W-1:0]  NUM_MAX  = ACC_W'((1 << NUM_W) - 1);
    localparam logic [DCNT_W-1:0] DIG_MAX  = DCNT_W'(MAX_DIGITS);
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {S_LETTER, S_DIGIT, S_SKIP} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                      state_q, state_d;
    logic [ACC_W-1:0]            acc_q, acc_d;
    logic [DCNT_W-1:0]           cnt_q, cnt_d;
    logic [LETTER_W-1:0]         letter_q, letter_d;
    logic [LETTER_W+NUM_W-1:0]   data_out_q, data_out_d;
    logic                        data_valid_q, data_valid_d;
    logic                        err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]            err_count_q, err_count_d;
    logic [CNT_W-1:0]            line_count_q, line_count_d;
    logic                        done_q, done_d;

    logic             slot_free, accept, eof_act, is_digit, err, emit;
    logic [ACC_W-1:0]  acc_next;
    logic [DCNT_W-1:0] cnt_next;

    assign slot_free  = !data_valid_q || data_ready;
    assign char_ready = slot_free && !done_q;
    assign accept     = char_valid && char_ready;
    // A byte accepted this cycle takes priority; eof is looked at once bytes stop.
    assign eof_act    = eof_in && !accept && slot_free && !done_q;
    assign is_digit   = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign acc_next   = acc_q * ACC_W'(10) + {{(ACC_W-4){1'b0}}, char_in[3:0]};
    assign cnt_next   = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        letter_d     = letter_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        err_count_d  = err_count_q;
        line_count_d = line_count_q;
        done_d       = done_q;
        err          = 1'b0;
        emit         = 1'b0;

        if (accept) begin
            case (state_q)
                S_LETTER: begin
                    if (char_in == CH_L || char_in == CH_R) begin
                        letter_d = char_in[LETTER_W-1:0];
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_DIGIT;
                    end else if (char_in != CH_CR && char_in != CH_LF) begin
                        err     = 1'b1;
                        state_d = S_SKIP;
                    end
                end
                S_DIGIT: begin
                    if (is_digit) begin
                        if (acc_next > NUM_MAX || cnt_next > DIG_MAX) begin
                            err     = 1'b1;
                            state_d = S_SKIP;
                        end else begin
                            acc_d = acc_next;
                            cnt_d = cnt_next;
                        end
                    end else if (char_in == CH_LF) begin
                        emit    = (cnt_q != '0);
                        err     = (cnt_q == '0);
                        state_d = S_LETTER;
                    end else if (char_in != CH_CR) begin
                        err     = 1'b1;
                        state_d = S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (char_in == CH_LF) state_d = S_LETTER;
                end
                default: state_d = S_LETTER;
            endcase
        end else if (eof_act) begin
            case (state_q)
                S_LETTER: done_d = !data_valid_q;
                S_DIGIT: begin
                    emit    = (cnt_q != '0);
                    err     = (cnt_q == '0);
                    state_d = S_LETTER;
                end
                S_SKIP: begin
                    err     = 1'b1;
                    state_d = S_LETTER;
                end
                default: state_d = S_LETTER;
            endcase
        end

        if (data_valid_q && data_ready) data_valid_d = 1'b0;
        if (emit) begin
            data_valid_d = 1'b1;
            data_out_d   = {letter_q, acc_q[NUM_W-1:0]};
            line_count_d = sat_inc(line_count_q);
        end
        err_pulse_d = err;
        if (err) err_count_d = sat_inc(err_count_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LETTER;
            acc_q        <= '0;
            cnt_q        <= '0;
            letter_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            line_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            letter_q     <= letter_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            line_count_q <= line_count_d;
            done_q       <= done_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign line_count = line_count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_puzzle1_line_parser.sv
// Directed bench for puzzle1_line_parser: nominal lines, CR/blank handling, limits,
// error recovery, backpressure, eof and mid-line reset.
module tb_puzzle1_line_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        eof_in;
    logic [16:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] line_count;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [16:0] words[$];
    int          errp = 0;
    int          vcnt = 0;
    logic        bp_sent;

    puzzle1_line_parser dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .eof_in     (eof_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .line_count (line_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && data_valid && data_ready) words.push_back(data_out);
        if (reset && err_pulse) errp++;
        if (data_valid) vcnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        char_in    = b;
        char_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = char_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        check("byte_accepted", {31'd0, rdy}, 32'd1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        char_valid = 1'b0;
    endtask

    initial begin
        logic stable_ok, blocked_ok;
        int   n;
        reset = 1'b0; char_in = 8'h00; char_valid = 1'b0; eof_in = 1'b0; data_ready = 1'b1;
        bp_sent = 1'b0;
        idle(2);
        check("rst_data_out",   {15'd0, data_out}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_err_pulse",  {31'd0, err_pulse}, 32'd0);
        check("rst_err_count",  {16'd0, err_count}, 32'd0);
        check("rst_line_count", {16'd0, line_count}, 32'd0);
        check("rst_done",       {31'd0, done}, 32'd0);
        reset = 1'b1;
        idle(1);
        check("rst_char_ready", {31'd0, char_ready}, 32'd1);

        // nominal line
        words.delete(); vcnt = 0;
        send_str("L68\n");
        idle(3);
        check("l68_nwords", words.size(), 32'd1);
        check("l68_word",   {15'd0, words[0]}, 32'h13044);
        check("l68_vcycles", vcnt, 32'd1);
        check("l68_lines",  {16'd0, line_count}, 32'd1);

        // CRLF and blank lines
        words.delete();
        send_str("\r\nR48\r\n\n");
        idle(3);
        check("crlf_nwords", words.size(), 32'd1);
        check("crlf_word",   {15'd0, words[0]}, 32'h14830);
        check("crlf_errs",   {16'd0, err_count}, 32'd0);

        // magnitude and digit-count limits
        words.delete();
        send_str("L1023\n");
        idle(3);
        check("max_nwords", words.size(), 32'd1);
        check("max_word",   {15'd0, words[0]}, 32'h133FF);
        words.delete(); errp = 0;
        send_str("R1024\n");
        idle(3);
        check("ovf_nwords", words.size(), 32'd0);
        check("ovf_pulses", errp, 32'd1);
        check("ovf_errs",   {16'd0, err_count}, 32'd1);
        errp = 0;
        send_str("L00007\n");
        idle(3);
        check("dig5_nwords", words.size(), 32'd0);
        check("dig5_pulses", errp, 32'd1);
        check("dig5_errs",   {16'd0, err_count}, 32'd2);
        send_str("R0\n");
        idle(3);
        check("zero_nwords", words.size(), 32'd1);
        check("zero_word",   {15'd0, words[0]}, 32'h14800);

        // recovery after syntax errors
        words.delete(); errp = 0;
        send_str("X5\nR1\n");
        idle(3);
        check("rec_nwords", words.size(), 32'd1);
        check("rec_word",   {15'd0, words[0]}, 32'h14801);
        check("rec_pulses", errp, 32'd1);
        check("rec_errs",   {16'd0, err_count}, 32'd3);
        words.delete(); errp = 0;
        send_str("L\n");
        idle(3);
        check("nodig_nwords", words.size(), 32'd0);
        check("nodig_errs",   {16'd0, err_count}, 32'd4);

        // backpressure
        words.delete();
        data_ready = 1'b0;
        fork
            begin
                send_str("L1\nR2\nL3\n");
                bp_sent = 1'b1;
            end
        join_none
        n = 0;
        while (!data_valid && n < 50) begin idle(1); n++; end
        check("bp_valid_up", {31'd0, data_valid}, 32'd1);
        stable_ok = 1'b1; blocked_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (data_out !== 17'h13001 || data_valid !== 1'b1) stable_ok = 1'b0;
            if (char_ready !== 1'b0) blocked_ok = 1'b0;
        end
        check("bp_stable",  {31'd0, stable_ok}, 32'd1);
        check("bp_blocked", {31'd0, blocked_ok}, 32'd1);
        check("bp_held_word", {15'd0, data_out}, 32'h13001);
        check("bp_none_out", words.size(), 32'd0);
        @(posedge clk); #1;
        data_ready = 1'b1;
        n = 0;
        while (!bp_sent && n < 200) begin idle(1); n++; end
        check("bp_sender_done", {31'd0, bp_sent}, 32'd1);
        idle(3);
        check("bp_nwords", words.size(), 32'd3);
        check("bp_word0",  {15'd0, words[0]}, 32'h13001);
        check("bp_word1",  {15'd0, words[1]}, 32'h14802);
        check("bp_word2",  {15'd0, words[2]}, 32'h13003);

        // end of file with an unterminated line
        words.delete();
        send_str("R7");
        eof_in = 1'b1;
        n = 0;
        while (!done && n < 50) begin idle(1); n++; end
        check("eof_done",   {31'd0, done}, 32'd1);
        check("eof_nwords", words.size(), 32'd1);
        check("eof_word",   {15'd0, words[0]}, 32'h14807);
        check("eof_lines",  {16'd0, line_count}, 32'd9);
        check("eof_errs",   {16'd0, err_count}, 32'd4);
        check("eof_ready",  {31'd0, char_ready}, 32'd0);
        idle(3);
        check("eof_done_held", {31'd0, done}, 32'd1);

        // reset in the middle of a line
        eof_in = 1'b0;
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        words.delete();
        send_str("L9\nL12");
        idle(2);
        check("pre_rst_lines", {16'd0, line_count}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_data_out", {15'd0, data_out}, 32'd0);
        check("mid_rst_valid",    {31'd0, data_valid}, 32'd0);
        check("mid_rst_lines",    {16'd0, line_count}, 32'd0);
        check("mid_rst_errs",     {16'd0, err_count}, 32'd0);
        check("mid_rst_done",     {31'd0, done}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);
        words.delete();
        send_str("R5\n");
        idle(3);
        check("post_rst_nwords", words.size(), 32'd1);
        check("post_rst_word",   {15'd0, words[0]}, 32'h14805);
        check("post_rst_lines",  {16'd0, line_count}, 32'd1);
        check("post_rst_errs",   {16'd0, err_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puzzle1_line_parser.md
Name: puzzle1_line_parser

Overview:
- Upstream front end for the day-1 dial solver (`puzzle1_1`).
- Converts a raw ASCII byte stream of rotation lines ("L68\n", "R48\r\n", ...) into the 17-bit word {letter[6:0], number[9:0]} that the solver's `data_in` consumes.
- Validates syntax, skips blank lines and CR, and presents each parsed line through a valid/ready handshake so the solver or a FIFO can apply backpressure.

Parameters:
- LETTER_W, 7, width of stored letter code (`char[6:0]`).
- NUM_W, 10, width of the rotation magnitude; maximum legal value is 2^NUM_W-1 = 1023.
- MAX_DIGITS, 4, maximum digit characters per line, leading zeros included.
- CNT_W, 16, width of the line and error counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- char_in  input  8  ASCII byte.
- char_valid  input  1  char_in is valid.
- char_ready  output  1  parser accepts a byte this cycle.
- eof_in  input  1  level; no further bytes will arrive.
- data_out  output  LETTER_W+NUM_W  {letter, number} of a parsed line.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  downstream accepts data_out.
- err_pulse  output  1  one-cycle pulse per rejected line.
- err_count  output  CNT_W  rejected lines, saturating.
- line_count  output  CNT_W  words emitted, saturating.
- done  output  1  eof seen, no partial line, output drained.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_LETTER; accumulator, digit count and letter cleared.
  - data_out=0, data_valid=0, err_pulse=0, err_count=0, line_count=0, done=0.
  - Reset mid-line discards the partial line and any pending output word.
- Byte acceptance: a byte is accepted when char_valid & char_ready.
  - char_ready = (!data_valid | data_ready) & !done.
  - Combinational from registered data_valid and input data_ready; no other combinational paths.
- Output handshake:
  - A word transfers when data_valid & data_ready.
  - data_out and data_valid are registered and hold stable until the transfer.
  - A new word may load in the same cycle as a transfer (back-to-back, full throughput).
- States:
  - S_LETTER:
    - 'L' (0x4C) or 'R' (0x52): store char[6:0], clear accumulator and digit count, go to S_DIGIT.
    - CR (0x0D) and LF (0x0A): ignored (blank lines).
    - Any other byte: error.
  - S_DIGIT:
    - '0'..'9': acc <= acc*10 + digit, using an internal NUM_W+4-bit accumulator; digit count +1.
    - Error if acc exceeds 1023 or the digit count exceeds MAX_DIGITS.
    - CR: ignored.
    - LF with digit count ≥1: emit a word, go to S_LETTER.
    - LF with zero digits: error.
    - Any other byte: error.
  - S_SKIP: discards bytes until LF, then goes to S_LETTER. LF itself is consumed.
- Error action:
  - err_pulse=1 for exactly one cycle; err_count +1, saturating at all-ones.
  - Go to S_SKIP. The LF that triggers an error goes directly to S_LETTER instead.
- Emit: on the cycle after the terminating LF is accepted, data_out = {letter, acc[NUM_W-1:0]}, data_valid=1, line_count +1 (saturating). Latency is one cycle from LF acceptance to data_valid.
- eof_in:
  - In S_DIGIT with ≥1 digit: treated as LF, so the word is emitted.
  - In S_DIGIT with zero digits, or in S_SKIP: counted as an error.
  - done=1 once eof_in=1, state is S_LETTER, and data_valid=0. done stays set until reset.
  - Bytes presented after done are not accepted.
- Simultaneous eof_in and char_valid: the byte is processed first; eof_in is evaluated from the next cycle.

Test Plan:
- Nominal line: "L68\n" with data_ready=1 → one word, data_out=17'h13044, data_valid for exactly 1 cycle, line_count=1.
- CRLF and blank line: "\r\nR48\r\n\n" → single word 17'h14830; err_count=0.
- Boundary values: "L1023\n" → 17'h133FF. "R1024\n" → err_pulse once, no word, err_count=1. "L00007\n" → error (5 digits). "R0\n" → 17'h14800.
- Error recovery: "X5\nR1\n" → err_count=1, single word 17'h14801; "L\n" → error, no word.
- Backpressure: stream "L1\nR2\nL3\n" with data_ready held low 20 cycles → first word 17'h13001 held stable, char_ready=0 while blocked; after release, 17'h13001, 17'h14802, 17'h13003 in order, nothing lost or duplicated.
- EOF and reset:
  - "R7" then eof_in=1 → word 17'h14807, then done=1 after transfer.
  - Separately, reset asserted after "L12" → all outputs 0; next "R5\n" yields only 17'h14805.
